// File: rtl/oafu_pkg.sv
// Shared types and constants for the operand-adaptive fused multiply unit (oafu).
// Mode encodings, control-bit positions and datapath widths.
package oafu_pkg;

  localparam int NUM_CL = 4;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 10;
  localparam int OUT_W  = 16;

  localparam int SX_SIGN = 3;
  localparam int SX_HI   = 1;
  localparam int SY_SIGN = 3;
  localparam int SY_HI   = 2;

  typedef enum logic [1:0] {
    MODE_DOT4    = 2'b00,
    MODE_DUAL_LO = 2'b01,
    MODE_DUAL_HI = 2'b10,
    MODE_FUSED8  = 2'b11
  } mode_e;

  // The B nibble of a cluster is scattered over bits [5:4] and [1:0] of its byte.
  function automatic logic [NIB_W-1:0] b_nibble(input logic [7:0] byte_in);
    return {byte_in[5:4], byte_in[1:0]};
  endfunction

endpackage

// File: rtl/oafu_cluster.sv
// One 4x4 nibble cluster: each operand is widened to 5 bits (sign- or zero-extended)
// and multiplied exactly into a 10-bit signed product.
module oafu_cluster
  import oafu_pkg::*;
(
  input  logic [NIB_W-1:0]         a,
  input  logic [NIB_W-1:0]         b,
  input  logic                     a_signed,
  input  logic                     b_signed,
  output logic signed [PROD_W-1:0] p
);

  logic signed [NIB_W:0] a_ext;
  logic signed [NIB_W:0] b_ext;

  assign a_ext = {a_signed & a[NIB_W-1], a};
  assign b_ext = {b_signed & b[NIB_W-1], b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/oafu.sv
// Operand-adaptive fused multiply unit: four nibble clusters combined as a fused 8x8,
// a 4-lane dot product or two 8-bit dual lanes. Two pipeline stages; define
// OAFU_ACC_EN to turn the output stage into a wrapping accumulator.
module oafu
  import oafu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic [3:0]              sx1,
  input  logic [3:0]              sx2,
  input  logic [3:0]              sx3,
  input  logic [3:0]              sx4,
  input  logic [3:0]              sy1,
  input  logic [3:0]              sy2,
  input  logic [3:0]              sy3,
  input  logic [3:0]              sy4,
  input  logic                    mode1,
  input  logic                    mode2,
  output logic signed [OUT_W-1:0] y
);

  logic [31:0]                   a_q;
  logic [31:0]                   b_q;
  logic [NUM_CL-1:0][3:0]        sx_q;
  logic [NUM_CL-1:0][3:0]        sy_q;
  mode_e                         mode_q;

  logic signed [PROD_W-1:0]      prod [NUM_CL];
  logic signed [OUT_W-1:0]       sum;

  // Stage 1: capture operands and all controls so they travel together.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      mode_q <= MODE_DOT4;
    end else begin
      a_q    <= a;
      b_q    <= b;
      sx_q   <= {sx4, sx3, sx2, sx1};
      sy_q   <= {sy4, sy3, sy2, sy1};
      mode_q <= mode_e'({mode1, mode2});
    end
  end

  for (genvar k = 0; k < NUM_CL; k++) begin : g_cl
    oafu_cluster u_cluster (
      .a        (a_q[8*k +: NIB_W]),
      .b        (b_nibble(b_q[8*k +: 8])),
      .a_signed (sx_q[k][SX_SIGN]),
      .b_signed (sy_q[k][SY_SIGN]),
      .p        (prod[k])
    );
  end

  logic signed [OUT_W-1:0] term;
  logic signed [OUT_W-1:0] fused_sum;
  logic signed [OUT_W-1:0] dot_sum;
  logic signed [OUT_W-1:0] lane_lo;
  logic signed [OUT_W-1:0] lane_hi;
  logic [3:0]              shamt;

  // NOTE: every variable gets a default at the top of the block so no path
  // through it can leave a value held, which would otherwise infer a latch.
  always_comb begin
    term      = '0;
    fused_sum = '0;
    dot_sum   = '0;
    lane_lo   = '0;
    lane_hi   = '0;
    shamt     = '0;
    for (int k = 0; k < NUM_CL; k++) begin
      term  = {{(OUT_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
      shamt = (sx_q[k][SX_HI] ? 4'd4 : 4'd0) + (sy_q[k][SY_HI] ? 4'd4 : 4'd0);
      fused_sum = fused_sum + (term <<< shamt);
      dot_sum   = dot_sum + term;
      if (k < NUM_CL/2) lane_lo = lane_lo + term;
      else              lane_hi = lane_hi + term;
    end
  end

  always_comb begin
    sum = '0;
    case (mode_q)
      MODE_FUSED8: sum = fused_sum;
      MODE_DOT4:   sum = dot_sum;
      default:     sum = {lane_hi[7:0], lane_lo[7:0]};
    endcase
  end

  // Stage 2: result register (or accumulator when OAFU_ACC_EN is defined).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
`ifdef OAFU_ACC_EN
      y <= y + sum;
`else
      y <= sum;
`endif
    end
  end

endmodule

// File: tb/tb_oafu.sv
// Self-checking bench for oafu: scoreboard queue of expected results, compared
// two edges after each operand set is driven.
module tb_oafu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a, b;
  logic [3:0]  sx1, sx2, sx3, sx4, sy1, sy2, sy3, sy4;
  logic        mode1, mode2;
  logic [15:0] y;

  oafu dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .sx1(sx1), .sx2(sx2), .sx3(sx3), .sx4(sx4),
    .sy1(sy1), .sy2(sy2), .sy3(sy3), .sy4(sy4),
    .mode1(mode1), .mode2(mode2), .y(y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one operation, advance one edge, and compare the result that is due now.
  task automatic drive(input logic [31:0] ai, input logic [31:0] bi,
                       input logic [15:0] sx, input logic [15:0] sy,
                       input logic [1:0] m, input string tag, input logic [15:0] e);
    exp_t x;
    a = ai;
    b = bi;
    {sx4, sx3, sx2, sx1} = sx;
    {sy4, sy3, sy2, sy1} = sy;
    {mode1, mode2} = m;
    sb_q.push_back('{tag, e});
    @(posedge clk); #1;
    if (sb_q.size() == 2) begin
      x = sb_q.pop_front();
      check(x.tag, y, x.val);
    end
  endtask

  task automatic drain();
    exp_t x;
    while (sb_q.size() > 0) begin
      @(posedge clk); #1;
      x = sb_q.pop_front();
      check(x.tag, y, x.val);
    end
  endtask

  function automatic logic [7:0] bp(input logic [3:0] n);
    return {2'b00, n[3:2], 2'b00, n[1:0]};
  endfunction

  // Fused packing: clusters 1..4 see (Alo,Blo), (Ahi,Blo), (Alo,Bhi), (Ahi,Bhi).
  function automatic logic [31:0] pack_a(input logic [7:0] c, input logic [31:0] junk);
    return {4'h0, c[7:4], 4'h0, c[3:0], 4'h0, c[7:4], 4'h0, c[3:0]} | (junk & 32'hF0F0_F0F0);
  endfunction

  function automatic logic [31:0] pack_b(input logic [7:0] d, input logic [31:0] junk);
    return {bp(d[7:4]), bp(d[7:4]), bp(d[3:0]), bp(d[3:0])} | (junk & 32'hCCCC_CCCC);
  endfunction

  task automatic fused_signed(input logic [7:0] c, input logic [7:0] d, input string tag);
    logic signed [7:0] cs, ds;
    int p;
    logic [31:0] j1, j2, j3;
    cs = c;
    ds = d;
    p  = cs * ds;
    j1 = $urandom;
    j2 = $urandom;
    j3 = $urandom;
    drive(pack_a(c, j1), pack_b(d, j2), 16'hA0A0 | (j3[15:0] & 16'h5555),
          16'hCC00 | (j3[31:16] & 16'h3333), 2'b11, tag, p[15:0]);
  endtask

  initial begin
    exp_t x;
    a = '0; b = '0;
    {sx4, sx3, sx2, sx1} = '0;
    {sy4, sy3, sy2, sy1} = '0;
    {mode1, mode2} = 2'b00;
    #12;
    check("reset_y", y, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fused signed corners with literal expectations.
    drive(pack_a(8'h80, 0), pack_b(8'h80, 0), 16'hA0A0, 16'hCC00, 2'b11, "f_m128_m128", 16'h4000);
    drive(pack_a(8'h80, 0), pack_b(8'h7F, 0), 16'hA0A0, 16'hCC00, 2'b11, "f_m128_127", 16'hC080);
    drive(pack_a(8'h00, 0), pack_b(8'hA5, 0), 16'hA0A0, 16'hCC00, 2'b11, "f_0_x", 16'h0000);
    drive(pack_a(8'h7F, 0), pack_b(8'h7F, 0), 16'hA0A0, 16'hCC00, 2'b11, "f_127_127", 16'h3F01);
    // Unsigned fused 255*255.
    drive(pack_a(8'hFF, 0), pack_b(8'hFF, 0), 16'h2020, 16'h4400, 2'b11, "f_unsigned_ff", 16'hFE01);
    // Dot4: products 1,2,4,9; shift bits set but must be ignored.
    drive({8'h03, 8'h02, 8'h01, 8'h0F}, {bp(4'h3), bp(4'h2), bp(4'h2), bp(4'hF)},
          16'hAAAA, 16'hCCCC, 2'b00, "dot4", 16'd16);
    // Dual lane: P1=7, P2=8, P3=-1, P4=3, both dual encodings.
    drive({8'h03, 8'h0F, 8'h04, 8'h07}, {bp(4'h1), bp(4'h1), bp(4'h2), bp(4'h1)},
          16'h0A00, 16'h4444, 2'b01, "dual01", 16'h020F);
    drive({8'h03, 8'h0F, 8'h04, 8'h07}, {bp(4'h1), bp(4'h1), bp(4'h2), bp(4'h1)},
          16'h0800, 16'h0000, 2'b10, "dual10", 16'h020F);
    // Dual lane wrap: low lane 450 -> C2, high lane -240 -> 10, no carry between lanes.
    drive({8'h08, 8'h08, 8'h0F, 8'h0F}, {bp(4'hF), bp(4'hF), bp(4'hF), bp(4'hF)},
          16'h8800, 16'h0000, 2'b10, "dual_wrap", 16'h10C2);
    drain();

    // Back-to-back throughput with changing operands.
    for (int i = 0; i < 8; i++) fused_signed($urandom, $urandom, "tput");
    drain();

    // Reset mid-stream: asynchronous clear, in-flight ops discarded.
    for (int i = 0; i < 4; i++) fused_signed($urandom, $urandom, "pre_rst");
    #3 rst_n = 1'b0;
    #1 check("rst_async", y, 16'h0000);
    sb_q.delete();
    @(posedge clk); #1;
    check("rst_hold", y, 16'h0000);
    #3 rst_n = 1'b1;
    fused_signed(8'h05, 8'h03, "post_rst_first");
    check("rst_no_stale", y, 16'h0000);
    fused_signed(8'hF9, 8'h06, "post_rst_second");
    drain();

    // Exhaustive fused signed sweep.
    for (int i = 0; i < 65536; i++) fused_signed(i[15:8], i[7:0], "fused_sweep");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
